alzette_ise_seq: RTL and testbench

- Multi-cycle Alzette ISE unit for the RV64 SPARKLE datapath.
- Executes one Alzette step (x/y add-rotate-xor with constant c) or the full 4-step Alzette box, in encrypt or decrypt direction.
- Sits beside the CPU execute stage behind a valid/ready request/response handshake, with a flush input.
- Parametrised in steps evaluated per cycle.

---
 rtl/alzette_ise_seq.sv | 276 +++++++++++++++++++++++++++
 tb/tb_alzette_ise_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alzette_ise_seq.sv
// -----------------------------------------------------------------------------
// alzette_ise_seq
//
// Multi-cycle Alzette instruction-set-extension unit for the RV64 SPARKLE
// datapath. It executes either one Alzette step (selected by a step index)
// or the complete four-step Alzette box, in the encrypt or decrypt direction.
// The unit sits beside the CPU execute stage and talks to it through a
// valid/ready request channel and a valid/ready response channel. A flush
// input aborts whatever is in flight.
//
// Parameters
//   UNROLL     steps evaluated per RUN cycle in full-box mode (1, 2 or 4)
//
// Ports
//   g_clk      in   1   clock, rising edge
//   g_rst      in   1   synchronous active-high reset
//   flush      in   1   abort the in-flight operation, return to IDLE
//   req_valid  in   1   request present
//   req_ready  out  1   unit is IDLE and can accept a request
//   req_rs1    in  64   [63:32] = y, [31:0] = x
//   req_rs2    in  64   [31:0] = round constant c, [63:32] ignored
//   req_funct  in   4   [3] full box, [2] decrypt, [1:0] step index (single)
//   rsp_valid  out  1   result available (state DONE)
//   rsp_ready  in   1   consumer takes the result
//   rsp_rd     out 64   registered result, [63:32] = y', [31:0] = x'
//   busy       out  1   state is not IDLE
// -----------------------------------------------------------------------------
module alzette_ise_seq #(
    parameter int UNROLL = 1
) (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_rs1,
    input  logic [63:0] req_rs2,
    input  logic [3:0]  req_funct,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rd,
    output logic        busy
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
            $error("alzette_ise_seq: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    // Number of RUN cycles needed for a full box.
    localparam logic [2:0] RUN_CYCLES = 3'(4 / UNROLL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Alzette step helpers
    // -------------------------------------------------------------------------

    function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] n);
        logic [63:0] t;
        t = {v, v} >> n;
        return t[31:0];
    endfunction

    // First rotation amount (applied to y when updating x).
    function automatic logic [4:0] rot_a(input logic [1:0] idx);
        logic [4:0] r;
        case (idx)
            2'd0:    r = 5'd31;
            2'd1:    r = 5'd17;
            2'd2:    r = 5'd0;
            default: r = 5'd24;
        endcase
        return r;
    endfunction

    // Second rotation amount (applied to x when updating y).
    function automatic logic [4:0] rot_b(input logic [1:0] idx);
        logic [4:0] r;
        case (idx)
            2'd0:    r = 5'd24;
            2'd1:    r = 5'd17;
            2'd2:    r = 5'd31;
            default: r = 5'd16;
        endcase
        return r;
    endfunction

    // Returns {y', x'}.
    function automatic logic [63:0] enc_step(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] c, input logic [1:0] idx);
        logic [31:0] xn;
        logic [31:0] yn;
        xn = x + rotr32(y, rot_a(idx));
        yn = y ^ rotr32(xn, rot_b(idx));
        xn = xn ^ c;
        return {yn, xn};
    endfunction

    // Exact inverse of enc_step: undo the three updates in reverse order.
    function automatic logic [63:0] dec_step(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] c, input logic [1:0] idx);
        logic [31:0] xn;
        logic [31:0] yn;
        xn = x ^ c;
        yn = y ^ rotr32(xn, rot_b(idx));
        xn = xn - rotr32(yn, rot_a(idx));
        return {yn, xn};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------

    state_t      state_q,   state_d;
    logic [31:0] x_q,       x_d;
    logic [31:0] y_q,       y_d;
    logic [31:0] c_q,       c_d;
    logic        full_q,    full_d;
    logic        dec_q,     dec_d;
    logic [1:0]  cnt_q,     cnt_d;
    logic [2:0]  left_q,    left_d;
    logic [63:0] rsp_rd_q,  rsp_rd_d;

    // -------------------------------------------------------------------------
    // Step chain: UNROLL consecutive steps starting at cnt_q. The result after
    // the first step serves single-step mode, the result after the last step
    // serves full-box mode. The index walks up (enc) or down (dec) and wraps
    // mod 4 naturally in two bits.
    // -------------------------------------------------------------------------

    logic [31:0] one_x;
    logic [31:0] one_y;
    logic [1:0]  one_idx;
    logic [31:0] all_x;
    logic [31:0] all_y;
    logic [1:0]  all_idx;

    always_comb begin
        logic [31:0] sx;
        logic [31:0] sy;
        logic [1:0]  si;
        logic [63:0] r;
        sx      = x_q;
        sy      = y_q;
        si      = cnt_q;
        r       = '0;
        one_x   = x_q;
        one_y   = y_q;
        one_idx = cnt_q;
        for (int i = 0; i < UNROLL; i++) begin
            r  = dec_q ? dec_step(sx, sy, c_q, si) : enc_step(sx, sy, c_q, si);
            sy = r[63:32];
            sx = r[31:0];
            si = dec_q ? (si - 2'd1) : (si + 2'd1);
            if (i == 0) begin
                one_x   = sx;
                one_y   = sy;
                one_idx = si;
            end
        end
        all_x   = sx;
        all_y   = sy;
        all_idx = si;
    end

    logic [31:0] step_x;
    logic [31:0] step_y;
    logic [1:0]  step_idx;

    assign step_x   = full_q ? all_x   : one_x;
    assign step_y   = full_q ? all_y   : one_y;
    assign step_idx = full_q ? all_idx : one_idx;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        c_d      = c_q;
        full_d   = full_q;
        dec_d    = dec_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        rsp_rd_d = rsp_rd_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    x_d    = req_rs1[31:0];
                    y_d    = req_rs1[63:32];
                    c_d    = req_rs2[31:0];
                    full_d = req_funct[3];
                    dec_d  = req_funct[2];
                    if (req_funct[3]) begin
                        cnt_d  = req_funct[2] ? 2'd3 : 2'd0;
                        left_d = RUN_CYCLES;
                    end else begin
                        cnt_d  = req_funct[1:0];
                        left_d = 3'd1;
                    end
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                x_d    = step_x;
                y_d    = step_y;
                cnt_d  = step_idx;
                left_d = left_q - 3'd1;
                if (left_q == 3'd1) begin
                    state_d = S_DONE;
                    // The response register only moves on a real RUN->DONE
                    // transition, so a flush on the last RUN cycle keeps it.
                    if (!flush) begin
                        rsp_rd_d = {step_y, step_x};
                    end
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides every transition, including request acceptance.
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= '0;
            full_q   <= 1'b0;
            dec_q    <= 1'b0;
            cnt_q    <= '0;
            left_q   <= '0;
            rsp_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            c_q      <= c_d;
            full_q   <= full_d;
            dec_q    <= dec_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            rsp_rd_q <= rsp_rd_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_alzette_ise_seq.sv
// -----------------------------------------------------------------------------
// Testbench for alzette_ise_seq. Three instances (UNROLL = 1, 2, 4) share all
// inputs; each response is compared against an independent reference model
// through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_alzette_ise_seq;

    logic        g_clk = 1'b0;
    logic        g_rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_rs1 = '0;
    logic [63:0] req_rs2 = '0;
    logic [3:0]  req_funct = '0;
    logic        rsp_ready = 1'b0;

    logic [2:0]  rq_rdy;
    logic [2:0]  vld;
    logic [2:0]  bsy;
    logic [63:0] rd [0:2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb_q[$];

    always #5 g_clk = ~g_clk;

    alzette_ise_seq #(.UNROLL(1)) u_dut1 (
        .g_clk(g_clk), .g_rst(g_rst), .flush(flush),
        .req_valid(req_valid), .req_ready(rq_rdy[0]),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct(req_funct),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rd(rd[0]), .busy(bsy[0])
    );

    alzette_ise_seq #(.UNROLL(2)) u_dut2 (
        .g_clk(g_clk), .g_rst(g_rst), .flush(flush),
        .req_valid(req_valid), .req_ready(rq_rdy[1]),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct(req_funct),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rd(rd[1]), .busy(bsy[1])
    );

    alzette_ise_seq #(.UNROLL(4)) u_dut4 (
        .g_clk(g_clk), .g_rst(g_rst), .flush(flush),
        .req_valid(req_valid), .req_ready(rq_rdy[2]),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct(req_funct),
        .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rd(rd[2]), .busy(bsy[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [63:0] model(input logic [63:0] rs1, input logic [31:0] c,
                                          input logic [3:0] f);
        int ra[4];
        int rb[4];
        int s;
        int nsteps;
        logic [31:0] x;
        logic [31:0] y;
        ra = '{31, 17, 0, 24};
        rb = '{24, 17, 31, 16};
        x = rs1[31:0];
        y = rs1[63:32];
        nsteps = f[3] ? 4 : 1;
        for (int k = 0; k < nsteps; k++) begin
            if (f[3]) s = f[2] ? (3 - k) : k;
            else      s = int'(f[1:0]);
            if (!f[2]) begin
                x = x + rr(y, ra[s]);
                y = y ^ rr(x, rb[s]);
                x = x ^ c;
            end else begin
                x = x ^ c;
                y = y ^ rr(x, rb[s]);
                x = x - rr(y, ra[s]);
            end
        end
        return {y, x};
    endfunction

    function automatic int lat_of(input int k, input logic full);
        int un;
        un = (k == 0) ? 1 : (k == 1) ? 2 : 4;
        return full ? (4 / un) : 1;
    endfunction

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 20 && rq_rdy !== 3'b111; i++) tick();
        n_cmp++;
        if (rq_rdy !== 3'b111) begin
            n_bad++;
            $display("FAIL wait_idle req_ready=%b required=111", rq_rdy);
        end
    endtask

    // Drive one request, wait for all three responses, compare result and latency.
    task automatic do_op(input logic [3:0] f, input logic [63:0] rs1, input logic [31:0] c,
                         input string tag, output logic [63:0] res);
        int lat [3];
        int cyc;
        logic [63:0] exp_v;
        wait_idle();
        req_valid = 1'b1;
        req_funct = f;
        req_rs1   = rs1;
        req_rs2   = {32'($urandom()), c};
        sb_q.push_back(model(rs1, c, f));
        tick();
        req_valid = 1'b0;
        req_rs1   = {32'($urandom()), 32'($urandom())};
        for (int k = 0; k < 3; k++) lat[k] = -1;
        cyc = 0;
        while (cyc < 10 && !(lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0)) begin
            tick();
            cyc++;
            for (int k = 0; k < 3; k++) if (vld[k] === 1'b1 && lat[k] < 0) lat[k] = cyc;
        end
        exp_v = sb_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (lat[k] != lat_of(k, f[3])) begin
                n_bad++;
                $display("FAIL %s_latency u%0d got=%0d want=%0d", tag, k, lat[k], lat_of(k, f[3]));
            end
            n_cmp++;
            if (rd[k] !== exp_v) begin
                n_bad++;
                $display("FAIL %s_rd u%0d got=%h want=%h", tag, k, rd[k], exp_v);
            end
        end
        res = rd[0];
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        g_rst = 1'b1;
        repeat (3) tick();
        g_rst = 1'b0;
        n_cmp++;
        if (rq_rdy !== 3'b111 || vld !== 3'b000 || bsy !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl rdy=%b vld=%b busy=%b want 111/000/000", rq_rdy, vld, bsy);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rd[k] !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_rd u%0d got=%h want=0", k, rd[k]);
            end
        end
    endtask

    task automatic test_single;
        logic [63:0] r;
        do_op(4'b0010, 64'h00000000_00000001, 32'h0, "enc_step2", r);
        n_cmp++;
        if (r !== 64'h00000002_00000001) begin
            n_bad++;
            $display("FAIL enc_step2_const got=%h want=%h", r, 64'h00000002_00000001);
        end
        do_op(4'b0110, 64'h00000002_00000001, 32'h0, "dec_step2", r);
        n_cmp++;
        if (r !== 64'h00000000_00000001) begin
            n_bad++;
            $display("FAIL dec_step2_const got=%h want=%h", r, 64'h00000000_00000001);
        end
        for (int i = 0; i < 40; i++) begin
            logic [3:0] f;
            f = {1'b0, 3'(i % 8)};
            do_op(f, {32'($urandom()), 32'($urandom())}, 32'($urandom()), "single_rand", r);
        end
    endtask

    task automatic test_full_box;
        logic [63:0] r;
        do_op(4'b1000, 64'd0, 32'd0, "full_zero", r);
        n_cmp++;
        if (r !== 64'd0) begin
            n_bad++;
            $display("FAIL full_zero_const got=%h want=0", r);
        end
        do_op(4'b1000, 64'h01234567_89ABCDEF, 32'hB7E15162, "full_enc_fix", r);
        do_op(4'b1100, 64'h01234567_89ABCDEF, 32'hB7E15162, "full_dec_fix", r);
    endtask

    task automatic test_round_trip;
        logic [63:0] orig;
        logic [63:0] e;
        logic [63:0] d;
        for (int i = 0; i < 1000; i++) begin
            orig = {32'($urandom()), 32'($urandom())};
            do_op(4'b1000, orig, 32'hB7E15162, "rt_enc", e);
            do_op(4'b1100, e, 32'hB7E15162, "rt_dec", d);
            n_cmp++;
            if (d !== orig) begin
                n_bad++;
                $display("FAIL round_trip got=%h want=%h", d, orig);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] exp_v;
        logic [63:0] rs1;
        rs1 = {32'($urandom()), 32'($urandom())};
        wait_idle();
        req_valid = 1'b1;
        req_funct = 4'b0001;
        req_rs1   = rs1;
        req_rs2   = {32'd0, 32'h13579BDF};
        sb_q.push_back(model(rs1, 32'h13579BDF, 4'b0001));
        tick();
        tick();
        exp_v = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_rs1   = {32'($urandom()), 32'($urandom())};
            req_funct = 4'($urandom());
            tick();
            n_cmp++;
            if (vld !== 3'b111 || rq_rdy !== 3'b000 || rd[0] !== exp_v) begin
                n_bad++;
                $display("FAIL backpressure_hold cyc%0d vld=%b rdy=%b rd=%h want 111/000/%h",
                         i, vld, rq_rdy, rd[0], exp_v);
            end
        end
        // Consume with a request still offered: it must not be accepted.
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_cmp++;
        if (bsy !== 3'b000 || rq_rdy !== 3'b111 || vld !== 3'b000) begin
            n_bad++;
            $display("FAIL consume_no_accept busy=%b rdy=%b vld=%b want 000/111/000", bsy, rq_rdy, vld);
        end
        n_cmp++;
        if (rd[0] !== exp_v) begin
            n_bad++;
            $display("FAIL rd_stable_after_consume got=%h want=%h", rd[0], exp_v);
        end
    endtask

    task automatic test_flush;
        logic [63:0] keep;
        logic        seen;
        // Flush during RUN.
        wait_idle();
        keep      = rd[0];
        req_valid = 1'b1;
        req_funct = 4'b1000;
        req_rs1   = 64'hDEADBEEF_CAFEF00D;
        tick();
        req_valid = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        n_cmp++;
        if (bsy !== 3'b000 || rq_rdy !== 3'b111 || vld !== 3'b000) begin
            n_bad++;
            $display("FAIL flush_run busy=%b rdy=%b vld=%b want 000/111/000", bsy, rq_rdy, vld);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (vld !== 3'b000) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_run_no_rsp rsp_valid rose got=1 want=0");
        end
        n_cmp++;
        if (rd[0] !== keep) begin
            n_bad++;
            $display("FAIL flush_run_rd got=%h want=%h", rd[0], keep);
        end
        // Flush together with a request in IDLE.
        req_valid = 1'b1;
        req_funct = 4'b0000;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        n_cmp++;
        if (bsy !== 3'b000 || rq_rdy !== 3'b111) begin
            n_bad++;
            $display("FAIL flush_with_req busy=%b rdy=%b want 000/111", bsy, rq_rdy);
        end
        tick();
        n_cmp++;
        if (vld !== 3'b000 || bsy !== 3'b000) begin
            n_bad++;
            $display("FAIL flush_with_req_later vld=%b busy=%b want 000/000", vld, bsy);
        end
        // Flush in DONE, with and without rsp_ready.
        for (int m = 0; m < 2; m++) begin
            req_valid = 1'b1;
            req_funct = 4'b0011;
            tick();
            req_valid = 1'b0;
            tick();
            n_cmp++;
            if (vld !== 3'b111) begin
                n_bad++;
                $display("FAIL flush_done_setup m%0d vld=%b want 111", m, vld);
            end
            flush     = 1'b1;
            rsp_ready = (m == 0);
            tick();
            flush     = 1'b0;
            rsp_ready = 1'b0;
            n_cmp++;
            if (vld !== 3'b000 || bsy !== 3'b000) begin
                n_bad++;
                $display("FAIL flush_done m%0d vld=%b busy=%b want 000/000", m, vld, bsy);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        logic [63:0] r;
        do_op(4'b1000, 64'h00000001_00000001, 32'h0000_0001, "pre_reset", r);
        n_cmp++;
        if (r === 64'd0) begin
            n_bad++;
            $display("FAIL pre_reset_nonzero got=%h want nonzero", r);
        end
        wait_idle();
        req_valid = 1'b1;
        req_funct = 4'b1000;
        req_rs1   = 64'h11111111_22222222;
        tick();
        req_valid = 1'b0;
        tick();
        g_rst = 1'b1;
        tick();
        g_rst = 1'b0;
        n_cmp++;
        if (bsy !== 3'b000 || vld !== 3'b000 || rq_rdy !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_mid_run busy=%b vld=%b rdy=%b want 000/000/111", bsy, vld, rq_rdy);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (rd[k] !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_mid_run_rd u%0d got=%h want=0", k, rd[k]);
            end
        end
        do_op(4'b1100, 64'h0F0F0F0F_F0F0F0F0, 32'h89ABCDEF, "after_reset", r);
    endtask

    task automatic test_back_to_back;
        logic [63:0] r;
        for (int i = 0; i < 20; i++) begin
            do_op({1'b1, 1'(i % 2), 2'b00}, {32'($urandom()), 32'($urandom())},
                  32'($urandom()), "b2b", r);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_box();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
        test_back_to_back();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
